adc_seq_ctrl: RTL and testbench

Sequencer for the scope's two 12-bit serial ADCs (channel A, channel B), which share one chip-select and one serial clock.
- Generates adc_cs_n and adc_sclk from the system clock.
- Starts one conversion frame per programmable sample period.
- Shifts in both ADC data lines in parallel.
- Presents the sample pair to the capture/USB path with a valid/ready handshake plus sticky error flags.
- Sits between the ADC pins and the sample FIFO.

---
 rtl/adc_pkg.sv | 13 +
 rtl/adc_shift_pair.sv | 26 ++
 rtl/adc_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_adc_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the dual serial ADC sequencer.
package adc_pkg;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_W     = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CS_SETUP = 2'b01,
    SHIFT    = 2'b10,
    QUIET    = 2'b11
  } adc_state_t;
endpackage

// File: rtl/adc_shift_pair.sv
// Two lock-stepped shift registers (A, B) with a parallel capture into the sample registers.
module adc_shift_pair
  import adc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic                   capture,
  input  logic [1:0]             sdata,
  output logic [1:0][DATA_W-1:0] sample
);
  logic [1:0][DATA_W-2:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      sample <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (shift_en) sreg[c] <= {sreg[c][DATA_W-3:0], sdata[c]};
        // last bit goes straight into the sample, never through sreg
        if (capture) sample[c] <= {sreg[c], sdata[c]};
      end
    end
  end
endmodule

// File: rtl/adc_seq_ctrl.sv
// Frame sequencer for two 12-bit serial ADCs sharing cs_n/sclk; delivers sample pairs via valid/ready.
module adc_seq_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       rate_div,
  input  logic              clr_flags,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdata_a,
  input  logic              adc_sdata_b,
  output logic [DATA_W-1:0] sample_a,
  output logic [DATA_W-1:0] sample_b,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun,
  output logic              missed
);
  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = $clog2(FRAME_BITS);
  localparam int QCW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);
  localparam logic [BCW-1:0] BIT_KEEP = BCW'(LEAD_ZEROS);
  localparam logic [QCW-1:0] Q_LAST   = QCW'(QUIET_CYCLES - 1);

  adc_state_t           state;
  logic [DCW-1:0]       div_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [QCW-1:0]       qcnt;
  logic [15:0]          tcnt, period_q, period_eff;
  logic                 tick, rise, shift_en, capture;
  logic [1:0][DATA_W-1:0] smp;

  // rate_div is sampled on the first cycle of each period, so edits apply from the next wrap
  always_comb begin
    period_eff = (tcnt == '0) ? rate_div : period_q;
    tick       = enable && (tcnt == period_eff);
    rise       = (state == SHIFT) && (div_cnt == DIV_LAST) && !adc_sclk;
    shift_en   = rise && (bit_cnt >= BIT_KEEP) && (bit_cnt != BIT_LAST);
    capture    = rise && (bit_cnt == BIT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= '0;
      period_q <= '0;
    end else begin
      period_q <= period_eff;
      tcnt     <= (!enable || tick) ? '0 : tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      qcnt     <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
    end else begin
      case (state)
        IDLE: if (tick) begin
          state    <= CS_SETUP;
          adc_cs_n <= 1'b0;
          div_cnt  <= '0;
        end
        CS_SETUP: if (div_cnt == DIV_LAST) begin
          state   <= SHIFT;
          div_cnt <= '0;
          bit_cnt <= '0;
        end else div_cnt <= div_cnt + 1'b1;
        SHIFT: if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          adc_sclk <= ~adc_sclk;
          if (!adc_sclk) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              adc_cs_n <= 1'b1;
              state    <= QUIET;
              qcnt     <= '0;
            end
          end
        end else div_cnt <= div_cnt + 1'b1;
        QUIET: if (qcnt == Q_LAST) state <= IDLE;
               else qcnt <= qcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // set beats clear on the sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      missed       <= 1'b0;
    end else begin
      sample_valid <= capture | (sample_valid & ~sample_ready);
      overrun      <= (capture & sample_valid & ~sample_ready) | (overrun & ~clr_flags);
      missed       <= (tick & (state != IDLE)) | (missed & ~clr_flags);
    end
  end

  adc_shift_pair u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .capture  (capture),
    .sdata    ({adc_sdata_b, adc_sdata_a}),
    .sample   (smp)
  );

  assign sample_a = smp[0];
  assign sample_b = smp[1];
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: ADC pin model feeds frames, monitor checks pairs and frame timing.
module tb_adc_seq_ctrl;
  import adc_pkg::*;

  logic clk = 0, rst_n = 1, enable = 0, clr_flags = 0, sample_ready = 1;
  logic adc_sdata_a = 0, adc_sdata_b = 0;
  logic [15:0] rate_div = 16'd99;
  logic adc_cs_n, adc_sclk, sample_valid, busy, overrun, missed;
  logic [DATA_W-1:0] sample_a, sample_b;

  int total = 0, bad = 0;
  logic [15:0] word_a = 16'h0AC3, word_b = 16'h053C;
  int bidx = 0;
  logic [2*DATA_W-1:0] sbq[$];

  int cyc = 0, xfer_cnt = 0, last_xfer = -1, exp_period = 100, lowc = 0, rises = 0, qn = 0;
  bit per_chk = 0, pend = 0;
  logic prev_cs = 1, prev_sclk = 1;
  logic [2*DATA_W-1:0] pexp, qexp;

  always #5 clk = ~clk;

  adc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div), .clr_flags(clr_flags),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdata_a(adc_sdata_a), .adc_sdata_b(adc_sdata_b),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .overrun(overrun), .missed(missed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ADC pin model: shifts out one bit per sclk fall, MSB first
  always @(negedge adc_cs_n) bidx = 0;
  always @(negedge adc_sclk) if (!adc_cs_n && bidx < 16) begin
    adc_sdata_a = word_a[15-bidx];
    adc_sdata_b = word_b[15-bidx];
    bidx++;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      pend = 0; prev_cs = 1; prev_sclk = 1;
    end else begin
      if (prev_cs && !adc_cs_n) begin
        pend = 1; lowc = 0; rises = 0;
        pexp = {word_a[DATA_W-1:0], word_b[DATA_W-1:0]};
      end
      if (!adc_cs_n) lowc++;
      if (!prev_sclk && adc_sclk) rises++;
      if (!prev_cs && adc_cs_n && pend) begin
        chk("cs_low_cycles", lowc, 66);
        chk("sclk_rises", rises, 16);
        sbq.push_back(pexp);
        pend = 0;
      end
      if (sample_valid && sample_ready) begin
        xfer_cnt++;
        if (sbq.size() == 0) chk("sb_unexpected_valid", 1, 0);
        else begin
          qn = sbq.size();
          qexp = sbq[$];
          sbq.delete();
          chk("sample_a", sample_a, qexp[2*DATA_W-1:DATA_W]);
          chk("sample_b", sample_b, qexp[DATA_W-1:0]);
          if (qn > 1) chk("overrun_on_drop", overrun, 1);
        end
        if (per_chk && last_xfer >= 0) chk("valid_period", cyc - last_xfer, exp_period);
        last_xfer = cyc;
      end
      if (!per_chk) last_xfer = -1;
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
    end
  end

  task automatic wait_cs(input logic v);
    int n = 0;
    while (adc_cs_n !== v && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("wait_cs_timeout", adc_cs_n, v);
  endtask

  task automatic wait_sclk(input logic v);
    int n = 0;
    while (adc_sclk !== v && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("wait_sclk_timeout", adc_sclk, v);
  endtask

  task automatic quiesce();
    int n = 0;
    @(posedge clk); #1 enable = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("quiesce_idle", busy, 0);
    @(posedge clk); #1 sample_ready = 1;
    repeat (3) @(posedge clk);
    #1 clr_flags = 1;
    @(posedge clk); #1 clr_flags = 0;
  endtask

  initial begin
    int x0, lows;
    logic [2*DATA_W-1:0] e;
    #2 rst_n = 0;
    #1;
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_a", sample_a, 0);
    chk("rst_sample_b", sample_b, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_missed", missed, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: nominal, one pair every 100 cycles
    per_chk = 1; exp_period = 100; x0 = xfer_cnt;
    @(posedge clk); #1 enable = 1;
    repeat (480) @(negedge clk);
    chk("t1_xfers", xfer_cnt - x0, 4);
    chk("t1_missed", missed, 0);
    chk("t1_overrun", overrun, 0);
    per_chk = 0;
    quiesce();

    // 2: period shorter than a frame, every other tick dropped
    rate_div = 16'd49; per_chk = 1;
    @(posedge clk); #1 enable = 1;
    wait_cs(0); wait_cs(1);
    chk("t2_missed_set", missed, 1);
    @(posedge clk); #1 clr_flags = 1;
    @(posedge clk); #1 clr_flags = 0;
    @(negedge clk);
    chk("t2_missed_clr", missed, 0);
    wait_cs(0); wait_cs(1);
    chk("t2_missed_again", missed, 1);
    per_chk = 0;
    quiesce();

    // 3: consumer stalls across two frames
    rate_div = 16'd99;
    @(posedge clk); #1 sample_ready = 0; enable = 1;
    wait_cs(0); wait_cs(1);
    @(negedge clk);
    chk("t3_valid", sample_valid, 1);
    wait_cs(0);
    repeat (30) @(negedge clk);
    e = sbq[0];
    chk("t3_stable_a", sample_a, e[2*DATA_W-1:DATA_W]);
    chk("t3_stable_b", sample_b, e[DATA_W-1:0]);
    chk("t3_no_overrun_yet", overrun, 0);
    wait_cs(1);
    @(negedge clk);
    chk("t3_overrun", overrun, 1);
    chk("t3_valid_held", sample_valid, 1);
    chk("t3_sb_depth", sbq.size(), 2);
    @(posedge clk); #1 sample_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_valid_clr", sample_valid, 0);
    quiesce();

    // 4: clr_flags on the same edge as an overrun
    @(posedge clk); #1 sample_ready = 0; enable = 1;
    wait_cs(0); wait_cs(1);
    chk("t4_ovr_pre", overrun, 0);
    wait_cs(0);
    repeat (65) @(posedge clk);
    #1 clr_flags = 1;
    @(posedge clk); #1 clr_flags = 0;
    @(negedge clk);
    chk("t4_frame_end", adc_cs_n, 1);
    chk("t4_ovr_vs_clr", overrun, 1);
    quiesce();

    // 5: async reset mid-SHIFT, then a clean frame
    word_a = 16'($urandom); word_b = 16'($urandom);
    @(posedge clk); #1 enable = 1;
    wait_cs(0);
    for (int i = 0; i < 8; i++) begin wait_sclk(0); wait_sclk(1); end
    wait_sclk(0);
    chk("t5_in_shift", busy, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_cs_n", adc_cs_n, 1);
    chk("t5_rst_sclk", adc_sclk, 1);
    chk("t5_rst_valid", sample_valid, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    x0 = xfer_cnt;
    wait_cs(0); wait_cs(1);
    @(negedge clk);
    chk("t5_xfer", xfer_cnt - x0, 1);

    // 6: enable dropped mid-frame
    wait_cs(0);
    repeat (20) @(posedge clk);
    #1 enable = 0;
    x0 = xfer_cnt;
    wait_cs(1);
    @(negedge clk);
    chk("t6_xfer", xfer_cnt - x0, 1);
    lows = 0;
    repeat (300) begin @(negedge clk); if (!adc_cs_n) lows++; end
    chk("t6_no_cs", lows, 0);
    chk("t6_idle", busy, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
